// File: rtl/simd_inst_receiver_pkg.sv
// Shared definitions for the SIMD instruction link: opcodes, field
// positions, the decoded instruction struct and the issue FSM encoding.
package SimdInst_pkg;

  localparam logic [5:0] OP_NOP = 6'd0;
  localparam logic [5:0] OP_END = 6'd63;

  // Field positions inside a 32-bit instruction word; bits [10:4] are unused.
  localparam int OP_MSB   = 31;
  localparam int OP_LSB   = 26;
  localparam int DST_MSB  = 25;
  localparam int DST_LSB  = 21;
  localparam int SRC0_MSB = 20;
  localparam int SRC0_LSB = 16;
  localparam int SRC1_MSB = 15;
  localparam int SRC1_LSB = 11;
  localparam int RPT_MSB  = 3;
  localparam int RPT_LSB  = 0;

  typedef struct packed {
    logic [5:0] op;
    logic [4:0] dst;
    logic [4:0] src0;
    logic [4:0] src1;
    logic [3:0] rpt;
  } simd_inst_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_HALT  = 2'd2
  } issue_state_e;

  function automatic simd_inst_t decode_inst(input logic [31:0] w);
    simd_inst_t r;
    r.op   = w[OP_MSB:OP_LSB];
    r.dst  = w[DST_MSB:DST_LSB];
    r.src0 = w[SRC0_MSB:SRC0_LSB];
    r.src1 = w[SRC1_MSB:SRC1_LSB];
    r.rpt  = w[RPT_MSB:RPT_LSB];
    return r;
  endfunction

endpackage

// File: rtl/simd_inst_fifo.sv
// Synchronous DEPTH x W FIFO with registered pointers and occupancy count.
// Read data is the current head (asynchronous read of the storage array).
// Pushes at full and pops at empty are ignored.
module simd_inst_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 32
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       push_i,
  input  logic [W-1:0]               din_i,
  input  logic                       pop_i,
  output logic [W-1:0]               dout_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign dout_o  = mem_q[rptr_q];
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // Next pointer and occupancy values; pointers wrap naturally (DEPTH is a power of two).
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (do_push) wptr_d = wptr_q + 1'b1;
    if (do_pop)  rptr_d = rptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Pointer and count registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // Storage array; contents need no reset because occupancy gates every read.
  always_ff @(posedge i_clk) begin
    if (do_push) mem_q[wptr_q] <= din_i;
  end

endmodule

// File: rtl/simd_inst_receiver.sv
// Receiver for the SIMD instruction link. Instructions are buffered in a
// FIFO and expanded by a three-state issue FSM into rpt+1 lane-group beats.
// Both channels transfer in a cycle where rdy && ack are high.
// An END instruction parks the FSM in HALT until reset.
module simd_inst_receiver
  import SimdInst_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int INST_BW = 32,
  parameter int NGRP    = 16
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       inst_rdy,
  output logic                       inst_ack,
  input  logic [INST_BW-1:0]         inst_dat,
  output logic                       exe_rdy,
  input  logic                       exe_ack,
  output logic [5:0]                 exe_op,
  output logic [4:0]                 exe_dst,
  output logic [4:0]                 exe_src0,
  output logic [4:0]                 exe_src1,
  output logic [$clog2(NGRP)-1:0]    exe_grp,
  output logic                       exe_last,
  output logic                       o_idle,
  output logic [1:0]                 o_dbg_state,
  output logic [$clog2(DEPTH+1)-1:0] o_dbg_count
);

  localparam int GW = $clog2(NGRP);
  localparam int CW = $clog2(DEPTH + 1);

  logic [INST_BW-1:0] fifo_dout;
  logic               fifo_full, fifo_empty, fifo_pop;
  logic [CW-1:0]      fifo_count;
  simd_inst_t         head;
  logic               head_live;
  logic [GW-1:0]      head_last_grp;
  logic               unused_bits;

  issue_state_e  state_q, state_d;
  logic [5:0]    op_q, op_d;
  logic [4:0]    dst_q, dst_d, src0_q, src0_d, src1_q, src1_d;
  logic [GW-1:0] grp_q, grp_d;
  logic [GW-1:0] last_grp_q, last_grp_d;
  logic          last_q, last_d;

  // Highest lane-group index of an instruction: rpt, capped at NGRP-1.
  function automatic logic [GW-1:0] last_grp_of(input logic [3:0] rpt);
    if (32'(rpt) > NGRP - 1) return GW'(NGRP - 1);
    return GW'(rpt);
  endfunction

  simd_inst_fifo #(
    .DEPTH (DEPTH),
    .W     (INST_BW)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .push_i  (inst_ack),
    .din_i   (inst_dat),
    .pop_i   (fifo_pop),
    .dout_o  (fifo_dout),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  assign inst_ack      = inst_rdy && !fifo_full;
  assign head          = decode_inst(fifo_dout[31:0]);
  assign head_live     = !fifo_empty && (head.op != OP_NOP);
  assign head_last_grp = last_grp_of(head.rpt);
  assign unused_bits   = ^fifo_dout[10:4];

  // Issue FSM: pops heads, drops NOPs, steps lane groups, loads back-to-back.
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    dst_d      = dst_q;
    src0_d     = src0_q;
    src1_d     = src1_q;
    grp_d      = grp_q;
    last_grp_d = last_grp_q;
    last_d     = last_q;
    fifo_pop   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          if (head.op != OP_NOP) begin
            op_d       = head.op;
            dst_d      = head.dst;
            src0_d     = head.src0;
            src1_d     = head.src1;
            grp_d      = '0;
            last_grp_d = head_last_grp;
            last_d     = (head_last_grp == '0);
            state_d    = ST_ISSUE;
          end
        end
      end
      ST_ISSUE: begin
        if (exe_ack) begin
          if (last_q) begin
            if (op_q == OP_END) begin
              last_d  = 1'b0;
              state_d = ST_HALT;
            end else if (head_live) begin
              fifo_pop   = 1'b1;
              op_d       = head.op;
              dst_d      = head.dst;
              src0_d     = head.src0;
              src1_d     = head.src1;
              grp_d      = '0;
              last_grp_d = head_last_grp;
              last_d     = (head_last_grp == '0);
            end else begin
              last_d  = 1'b0;
              state_d = ST_IDLE;
            end
          end else begin
            grp_d  = grp_q + 1'b1;
            last_d = (grp_d == last_grp_q);
          end
        end
      end
      ST_HALT: begin
        state_d = ST_HALT;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Issue register, beat counter and FSM state.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= ST_IDLE;
      op_q       <= '0;
      dst_q      <= '0;
      src0_q     <= '0;
      src1_q     <= '0;
      grp_q      <= '0;
      last_grp_q <= '0;
      last_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      dst_q      <= dst_d;
      src0_q     <= src0_d;
      src1_q     <= src1_d;
      grp_q      <= grp_d;
      last_grp_q <= last_grp_d;
      last_q     <= last_d;
    end
  end

  assign exe_rdy     = (state_q == ST_ISSUE);
  assign exe_op      = op_q;
  assign exe_dst     = dst_q;
  assign exe_src0    = src0_q;
  assign exe_src1    = src1_q;
  assign exe_grp     = grp_q;
  assign exe_last    = last_q;
  assign o_idle      = (state_q == ST_IDLE) && (fifo_count == '0);
  assign o_dbg_state = state_q;
  assign o_dbg_count = fifo_count;

endmodule

// File: tb/tb_simd_inst_receiver.sv
// Bench for simd_inst_receiver: directed instruction streams, expected beats
// queued at issue time, and a negedge monitor that pops and compares beats.
module tb_simd_inst_receiver;

  localparam int BW = 26;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        inst_rdy;
  logic        inst_ack;
  logic [31:0] inst_dat;
  logic        exe_rdy;
  logic        exe_ack;
  logic [5:0]  exe_op;
  logic [4:0]  exe_dst, exe_src0, exe_src1;
  logic [3:0]  exe_grp;
  logic        exe_last;
  logic        o_idle;
  logic [1:0]  o_dbg_state;
  logic [2:0]  o_dbg_count;

  simd_inst_receiver #(.DEPTH(4), .INST_BW(32), .NGRP(16)) dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .inst_rdy    (inst_rdy),
    .inst_ack    (inst_ack),
    .inst_dat    (inst_dat),
    .exe_rdy     (exe_rdy),
    .exe_ack     (exe_ack),
    .exe_op      (exe_op),
    .exe_dst     (exe_dst),
    .exe_src0    (exe_src0),
    .exe_src1    (exe_src1),
    .exe_grp     (exe_grp),
    .exe_last    (exe_last),
    .o_idle      (o_idle),
    .o_dbg_state (o_dbg_state),
    .o_dbg_count (o_dbg_count)
  );

  // ---------------- clock / reset ----------------
  always #5 i_clk = ~i_clk;

  int cyc = 0;
  always @(posedge i_clk) cyc <= cyc + 1;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  logic [BW-1:0] exp_q[$];
  int            beat_cyc[$];
  int            n_chk = 0;
  int            n_pass = 0;
  int            beats_seen = 0;
  bit            mon_en = 1'b1;
  int            ack_mode = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [31:0] mk(input logic [5:0] op, input logic [4:0] dst,
                                     input logic [4:0] s0, input logic [4:0] s1,
                                     input logic [3:0] rpt);
    return {op, dst, s0, s1, 7'h55, rpt};
  endfunction

  task automatic exp_beats(input logic [5:0] op, input logic [4:0] dst, input logic [4:0] s0,
                           input logic [4:0] s1, input int nbeats);
    for (int g = 0; g < nbeats; g++)
      exp_q.push_back({op, dst, s0, s1, 4'(g), (g == nbeats - 1) ? 1'b1 : 1'b0});
  endtask

  // ---------------- exe_ack driver ----------------
  initial begin
    int pat;
    pat = 0;
    exe_ack = 1'b0;
    forever begin
      @(posedge i_clk);
      #1;
      case (ack_mode)
        1:       exe_ack = 1'b1;
        2: begin exe_ack = (pat % 3 == 0); pat++; end
        default: exe_ack = 1'b0;
      endcase
    end
  end

  // ---------------- monitor ----------------
  initial begin
    logic [BW-1:0] cur, held;
    bit            stall_prev;
    stall_prev = 1'b0;
    held = '0;
    forever begin
      @(negedge i_clk);
      cur = {exe_op, exe_dst, exe_src0, exe_src1, exe_grp, exe_last};
      if (!mon_en || i_rst) begin
        stall_prev = 1'b0;
      end else begin
        if (stall_prev) check("stall_hold", {exe_rdy, cur}, {1'b1, held});
        if (exe_rdy && exe_ack) begin
          beats_seen++;
          beat_cyc.push_back(cyc);
          check("beat_expected", 32'(exp_q.size() != 0), 32'd1);
          if (exp_q.size() != 0) check("beat", cur, exp_q.pop_front());
        end
        stall_prev = exe_rdy && !exe_ack;
        held = cur;
      end
    end
  end

  // ---------------- instruction driver ----------------
  task automatic send(input logic [31:0] w, input int budget, output bit acc);
    acc = 1'b0;
    inst_rdy = 1'b1;
    inst_dat = w;
    for (int c = 0; c < budget && !acc; c++) begin
      @(negedge i_clk);
      if (inst_ack) acc = 1'b1;
      @(posedge i_clk);
      #1;
    end
    inst_rdy = 1'b0;
  endtask

  task automatic cycles(input int n);
    for (int c = 0; c < n; c++) begin
      @(posedge i_clk);
      #1;
    end
  endtask

  task automatic wait_drain(input string name, input int budget);
    for (int c = 0; c < budget && !(exp_q.size() == 0 && o_idle); c++) begin
      @(posedge i_clk);
      #1;
    end
    check(name, {31'(exp_q.size()), o_idle}, 32'd1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bit acc;
    int b0;
    int bad;
    i_rst = 1'b1;
    inst_rdy = 1'b0;
    inst_dat = '0;
    cycles(3);

    // Reset state, with inst_rdy probing the combinational accept path.
    inst_rdy = 1'b1;
    #1;
    check("rst_inst_ack", inst_ack, 1);
    check("rst_exe_rdy", exe_rdy, 0);
    check("rst_exe_fields", {exe_op, exe_dst, exe_src0, exe_src1, exe_grp, exe_last}, 0);
    check("rst_idle", o_idle, 1);
    check("rst_count", o_dbg_count, 0);
    inst_rdy = 1'b0;
    cycles(1);
    i_rst = 1'b0;
    ack_mode = 1;
    cycles(2);

    // Single instruction: 3 beats, latency 2, consecutive cycles.
    beat_cyc.delete();
    exp_beats(6'd5, 5'd1, 5'd2, 5'd3, 3);
    send(mk(6'd5, 5'd1, 5'd2, 5'd3, 4'd2), 4, acc);
    check("single_acc", acc, 1);
    check("single_lat_t1", exe_rdy, 0);
    cycles(1);
    check("single_lat_t2", exe_rdy, 1);
    wait_drain("single_drain", 20);
    check("single_nbeats", beat_cyc.size(), 3);
    if (beat_cyc.size() == 3) check("single_consec", beat_cyc[2] - beat_cyc[0], 2);

    // Back-pressure: ack pattern 1,0,0 repeating.
    ack_mode = 2;
    exp_beats(6'd21, 5'd7, 5'd8, 5'd9, 6);
    send(mk(6'd21, 5'd7, 5'd8, 5'd9, 4'd5), 4, acc);
    exp_beats(6'd33, 5'd30, 5'd29, 5'd28, 3);
    send(mk(6'd33, 5'd30, 5'd29, 5'd28, 4'd2), 4, acc);
    wait_drain("bp_drain", 200);

    // FIFO full: 4 buffered + 1 in issue, the sixth is refused.
    ack_mode = 0;
    cycles(2);
    for (int i = 0; i < 6; i++) begin
      send(mk(6'(10 + i), 5'(i), 5'(i + 1), 5'(i + 2), 4'd0), 3, acc);
      check("full_acc", acc, (i < 5) ? 1 : 0);
      if (acc) exp_beats(6'(10 + i), 5'(i), 5'(i + 1), 5'(i + 2), 1);
    end
    check("full_count", o_dbg_count, 4);
    check("full_inst_ack", inst_ack, 0);
    beat_cyc.delete();
    ack_mode = 1;
    wait_drain("full_drain", 50);
    check("full_nbeats", beat_cyc.size(), 5);
    if (beat_cyc.size() == 5) check("full_b2b", beat_cyc[4] - beat_cyc[0], 4);

    // NOP filtering.
    b0 = beats_seen;
    send(mk(6'd0, 5'd3, 5'd3, 5'd3, 4'd2), 4, acc);
    exp_beats(6'd7, 5'd4, 5'd5, 5'd6, 1);
    send(mk(6'd7, 5'd4, 5'd5, 5'd6, 4'd0), 4, acc);
    send(mk(6'd0, 5'd1, 5'd1, 5'd1, 4'd0), 4, acc);
    exp_beats(6'd9, 5'd10, 5'd11, 5'd12, 2);
    send(mk(6'd9, 5'd10, 5'd11, 5'd12, 4'd1), 4, acc);
    wait_drain("nop_drain", 30);
    check("nop_nbeats", beats_seen - b0, 3);

    // END halt: one beat, then op 4 stays buffered.
    b0 = beats_seen;
    exp_beats(6'd63, 5'd2, 5'd4, 5'd6, 1);
    send(mk(6'd63, 5'd2, 5'd4, 5'd6, 4'd0), 4, acc);
    send(mk(6'd4, 5'd1, 5'd1, 5'd1, 4'd0), 4, acc);
    check("end_acc_op4", acc, 1);
    cycles(8);
    check("end_nbeats", beats_seen - b0, 1);
    check("end_q_empty", exp_q.size(), 0);
    check("end_exe_rdy", exe_rdy, 0);
    check("end_state", o_dbg_state, 2);
    check("end_count", o_dbg_count, 1);
    check("end_idle", o_idle, 0);
    i_rst = 1'b1;
    cycles(1);
    i_rst = 1'b0;
    check("end_rst_count", o_dbg_count, 0);
    check("end_rst_idle", o_idle, 1);
    cycles(2);

    // Reset during grp=1 of an rpt=3 instruction.
    mon_en = 1'b0;
    send(mk(6'd11, 5'd5, 5'd6, 5'd7, 4'd3), 4, acc);
    acc = 1'b0;
    for (int c = 0; c < 10 && !acc; c++) begin
      @(negedge i_clk);
      if (exe_rdy && exe_grp == 4'd1) acc = 1'b1;
    end
    check("mid_reached_grp1", acc, 1);
    i_rst = 1'b1;
    @(posedge i_clk);
    #1;
    i_rst = 1'b0;
    check("mid_exe_rdy", exe_rdy, 0);
    check("mid_count", o_dbg_count, 0);
    bad = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge i_clk);
      if (exe_rdy) bad++;
    end
    check("mid_no_beats", bad, 0);
    check("mid_idle", o_idle, 1);
    mon_en = 1'b1;

    check("final_q_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
